// File: rtl/vector_frame_mux.sv
// N-source frame multiplexer for the vector display: priority source selection that only changes
// at frame boundaries once the request has persisted. Optional stats outputs: FRAME_MUX_STATS_EN.

module vector_frame_mux_lane #(
    parameter int AW = 16,
    parameter int DW = 18
) (
    input  logic          sel,
    input  logic [AW-1:0] disp_addr,
    output logic [AW-1:0] src_addr,
    input  logic [DW-1:0] src_data,
    output logic [DW-1:0] data_gated
);
    // Unselected lanes see address 0 and contribute nothing to the AND-OR read mux.
    assign src_addr   = sel ? disp_addr : '0;
    assign data_gated = sel ? src_data  : '0;
endmodule

module vector_frame_mux #(
    parameter int                   NSRC          = 4,
    parameter int                   ADDRESSWIDTH  = 16,
    parameter int                   DATAWIDTH     = 18,
    parameter int                   DEFAULT_SRC   = 0,
    parameter int                   STABLE_FRAMES = 2,
    parameter logic [DATAWIDTH-1:0] END_WORD      = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NSRC-1:0]              sel_req,
    input  logic [NSRC-1:0]              src_ready,
    input  logic                         frame_done,
    input  logic [ADDRESSWIDTH-1:0]      disp_addr,
    output logic [DATAWIDTH-1:0]         disp_data,
    output logic                         go,
    output logic [NSRC*ADDRESSWIDTH-1:0] src_addr,
    input  logic [NSRC*DATAWIDTH-1:0]    src_data,
    output logic [$clog2(NSRC)-1:0]      active_src,
    output logic                         switch_pulse
`ifdef FRAME_MUX_STATS_EN
    ,
    output logic [15:0]                  frame_cnt,
    output logic [7:0]                   switch_cnt
`endif
);
    localparam int SW = $clog2(NSRC);
    localparam int CW = $clog2(STABLE_FRAMES + 1);

    typedef enum logic [1:0] {S_WAIT, S_RUN, S_EVAL} state_t;

    state_t                            state, state_nx;
    logic   [SW-1:0]                   cand, prev_cand, prev_nx, active_nx;
    logic   [CW-1:0]                   cnt, cnt_nx, cnt_try;
    logic                              pulse_nx;
    logic   [NSRC-1:0][DATAWIDTH-1:0]  lane_data;
    logic   [DATAWIDTH-1:0]            sel_data;

    for (genvar i = 0; i < NSRC; i++) begin : g_lane
        vector_frame_mux_lane #(.AW(ADDRESSWIDTH), .DW(DATAWIDTH)) u_lane (
            .sel        (active_src == SW'(i)),
            .disp_addr  (disp_addr),
            .src_addr   (src_addr[i*ADDRESSWIDTH +: ADDRESSWIDTH]),
            .src_data   (src_data[i*DATAWIDTH +: DATAWIDTH]),
            .data_gated (lane_data[i])
        );
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NSRC; i++) sel_data |= lane_data[i];
    end

    // Ascending scan: the last set bit wins, so the highest index has priority.
    always_comb begin
        cand = SW'(DEFAULT_SRC);
        for (int i = 0; i < NSRC; i++)
            if (sel_req[i]) cand = SW'(i);
    end

    always_comb begin
        state_nx  = state;
        active_nx = active_src;
        cnt_nx    = cnt;
        prev_nx   = prev_cand;
        pulse_nx  = 1'b0;
        cnt_try   = '0;
        case (state)
            S_WAIT: if (src_ready[active_src]) state_nx = S_RUN;
            S_RUN:  if (frame_done) state_nx = S_EVAL;
            S_EVAL: begin
                state_nx = S_WAIT;
                prev_nx  = cand;
                if (cand == active_src) begin
                    cnt_nx = '0;
                end else begin
                    if (cand == prev_cand)
                        cnt_try = (cnt == CW'(STABLE_FRAMES)) ? cnt : cnt + 1'b1;
                    else
                        cnt_try = CW'(1);
                    if (cnt_try >= CW'(STABLE_FRAMES)) begin
                        active_nx = cand;
                        cnt_nx    = '0;
                        pulse_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt_try;
                    end
                end
            end
            default: state_nx = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_WAIT;
            active_src   <= SW'(DEFAULT_SRC);
            prev_cand    <= SW'(DEFAULT_SRC);
            cnt          <= '0;
            switch_pulse <= 1'b0;
            go           <= 1'b0;
            disp_data    <= END_WORD;
        end else begin
            state        <= state_nx;
            active_src   <= active_nx;
            prev_cand    <= prev_nx;
            cnt          <= cnt_nx;
            switch_pulse <= pulse_nx;
            go           <= (state_nx == S_RUN);
            disp_data    <= (state == S_RUN) ? sel_data : END_WORD;
        end
    end

`ifdef FRAME_MUX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt  <= '0;
            switch_cnt <= '0;
        end else begin
            if (state == S_EVAL) frame_cnt <= frame_cnt + 16'd1;
            if (pulse_nx && switch_cnt != 8'hFF) switch_cnt <= switch_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_vector_frame_mux.sv
// Randomised bench for vector_frame_mux against a frame-level reference model, plus literal checks.

module tb_vector_frame_mux;
    localparam int NSRC = 4;
    localparam int AW   = 16;
    localparam int DW   = 18;
    localparam int SF   = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NSRC-1:0]      sel_req, src_ready;
    logic                 frame_done;
    logic [AW-1:0]        disp_addr;
    logic [DW-1:0]        disp_data;
    logic                 go;
    logic [NSRC*AW-1:0]   src_addr;
    logic [NSRC*DW-1:0]   src_data;
    logic [1:0]           active_src;
    logic                 switch_pulse;
`ifdef FRAME_MUX_STATS_EN
    logic [15:0]          frame_cnt;
    logic [7:0]           switch_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    vector_frame_mux #(.NSRC(NSRC), .ADDRESSWIDTH(AW), .DATAWIDTH(DW), .DEFAULT_SRC(0),
                       .STABLE_FRAMES(SF), .END_WORD('0)) dut (
        .clk(clk), .rst_n(rst_n), .sel_req(sel_req), .src_ready(src_ready),
        .frame_done(frame_done), .disp_addr(disp_addr), .disp_data(disp_data), .go(go),
        .src_addr(src_addr), .src_data(src_data), .active_src(active_src),
        .switch_pulse(switch_pulse)
`ifdef FRAME_MUX_STATS_EN
        , .frame_cnt(frame_cnt), .switch_cnt(switch_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Source image contents: a distinct pattern per source, with src 0 @ 0x0005 = 0x12345.
    function automatic logic [DW-1:0] pat(int s, logic [AW-1:0] a);
        return 18'h12345 + DW'(s) * 18'h0F0F1 + (DW'(a) - 18'd5) * 18'h00101;
    endfunction

    always_comb begin
        src_data = '0;
        for (int i = 0; i < NSRC; i++) src_data[i*DW +: DW] = pat(i, src_addr[i*AW +: AW]);
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame phase (0 waiting, 1 drawing, 2 boundary), selection and streak.
    int            m_phase, m_active, m_prev, m_cnt, m_frames, m_sw;
    logic          m_pulse;
    logic [DW-1:0] m_dd;

    function automatic int cand_of(logic [NSRC-1:0] r);
        for (int i = NSRC - 1; i >= 0; i--) if (r[i]) return i;
        return 0;
    endfunction

    function automatic int streak(int c, int prev, int cnt);
        if (c != prev) return 1;
        return (cnt + 1 > SF) ? SF : cnt + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_active <= 0; m_prev <= 0; m_cnt <= 0;
            m_pulse <= 1'b0; m_dd <= '0;
        end else begin
            m_pulse <= 1'b0;
            m_dd    <= (m_phase == 1) ? pat(m_active, disp_addr) : '0;
            case (m_phase)
                0: if (src_ready[m_active]) m_phase <= 1;
                1: if (frame_done) m_phase <= 2;
                default: begin
                    m_phase  <= 0;
                    m_frames <= m_frames + 1;
                    m_prev   <= cand_of(sel_req);
                    if (cand_of(sel_req) == m_active) m_cnt <= 0;
                    else if (streak(cand_of(sel_req), m_prev, m_cnt) >= SF) begin
                        m_active <= cand_of(sel_req);
                        m_cnt    <= 0;
                        m_pulse  <= 1'b1;
                        m_sw     <= m_sw + 1;
                    end else m_cnt <= streak(cand_of(sel_req), m_prev, m_cnt);
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic [NSRC*AW-1:0] exp_addr;
            exp_addr = '0;
            exp_addr[m_active*AW +: AW] = disp_addr;
            chk("go", go, m_phase == 1);
            chk("active_src", active_src, m_active);
            chk("switch_pulse", switch_pulse, m_pulse);
            chk("disp_data", disp_data, m_dd);
            chk("src_addr", src_addr, exp_addr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_done = 1'b1; step();
        frame_done = 1'b0; step();
        step();
    endtask

    initial begin
        m_frames = 0; m_sw = 0;
        rst_n = 1'b0; sel_req = '0; src_ready = '0; frame_done = 1'b0; disp_addr = '0;
        #1 started = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        chk("rst_go", go, 0);
        chk("rst_disp_data", disp_data, 0);
        chk("rst_active", active_src, 0);
        step();
        chk("wait_go", go, 0);

        src_ready = 4'b0001;
        step(); step();
        chk("t1_go", go, 1);

        disp_addr = 16'h0005;
        step();
        chk("t2_disp_data", disp_data, 18'h12345);
        chk("t2_addr_other", src_addr[NSRC*AW-1:AW], 0);
        chk("t2_addr0", src_addr[AW-1:0], 16'h0005);

        sel_req = 4'b0100;
        frame_done = 1'b1; step(); frame_done = 1'b0; step();
        chk("t3_first_eval", active_src, 0);
        chk("t3_no_pulse", switch_pulse, 0);
        step();
        frame_done = 1'b1; step(); frame_done = 1'b0; step();
        chk("t3_switched", active_src, 2);
        chk("t3_pulse", switch_pulse, 1);
        src_ready = 4'b1111;
        step();
        chk("t3_pulse_one", switch_pulse, 0);

        for (int k = 0; k < 6; k++) begin
            sel_req = (k % 2 == 0) ? 4'b1000 : 4'b0010;
            frame();
        end
        chk("t4_no_switch", active_src, 2);

        sel_req = 4'b1000;
        frame(); frame();
        chk("t5_on_src3", active_src, 3);
        chk("t5_running", go, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_go", go, 0);
        chk("t5_async_active", active_src, 0);
        chk("t5_async_data", disp_data, 0);
        step();
        rst_n = 1'b1;

        for (int c = 0; c < 4000; c++) begin
            step();
            frame_done = ($urandom_range(0, 3) == 0);
            disp_addr  = AW'($urandom);
            if ($urandom_range(0, 15) == 0) sel_req = NSRC'($urandom);
            if ($urandom_range(0, 7) == 0)  src_ready = NSRC'($urandom) | NSRC'($urandom);
            if (c == 2000) rst_n = 1'b0;
            if (c == 2002) rst_n = 1'b1;
        end
        frame_done = 1'b0;
        step();
`ifdef FRAME_MUX_STATS_EN
        chk("stat_switch_cnt", switch_cnt, (m_sw > 255) ? 255 : m_sw);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

`ifdef FRAME_MUX_STATS_EN
    always @(negedge rst_n) begin
        m_frames <= 0;
        m_sw     <= 0;
    end
    always @(negedge clk) if (started && rst_n) chk("frame_cnt", frame_cnt, 16'(m_frames));
`endif
endmodule
